// File: rtl/lc3b_types.sv
// Shared types for the L2 / victim-cache / physical-memory slice.
// The line sizes here match the default parameters of pmem_wb_arbiter.
package lc3b_types;

    localparam int LINE_ADDR_BITS = 12;
    localparam int LINE_BITS      = 128;

    typedef logic [LINE_ADDR_BITS-1:0] lc3b_line_addr;
    typedef logic [LINE_BITS-1:0]      lc3b_line;

    // WB and FILL double as the "last_grant" record used by round-robin.
    typedef enum logic [1:0] {
        IDLE,
        WB,
        FILL,
        RESP
    } pmem_arb_state_t;

endpackage

// File: rtl/pmem_wb_arbiter.sv
// Owner of the single physical-memory port. Arbitrates between victim-cache
// dirty-line writebacks and L2 line fills. Every access runs from registers
// latched on the grant edge, so requester inputs may churn afterwards.
module pmem_wb_arbiter
    import lc3b_types::*;
#(
    parameter int LINE_ADDR_W = 12,
    parameter int LINE_W      = 128,
    parameter int OFFSET_W    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         vc_write,
    input  logic [LINE_ADDR_W-1:0]       vc_address,
    input  logic [LINE_W-1:0]            vc_wdata,
    output logic                         mem_ack,
    input  logic                         l2_read,
    input  logic [LINE_ADDR_W-1:0]       l2_address,
    output logic [LINE_W-1:0]            l2_rdata,
    output logic                         l2_resp,
    output logic                         L2toPmem_busy,
    output logic                         pmem_read,
    output logic                         pmem_write,
    output logic [LINE_ADDR_W+OFFSET_W-1:0] pmem_address,
    output logic [LINE_W-1:0]            pmem_wdata,
    input  logic [LINE_W-1:0]            pmem_rdata,
    input  logic                         pmem_resp
);

    pmem_arb_state_t state;
    pmem_arb_state_t last_grant;
    logic            start_access;
    logic            pick_wb;

    // Writeback wins when alone, or on a same-line hazard so the fill that
    // follows reads the freshly written data; otherwise alternate.
    function automatic logic grant_writeback(
        input logic            vc_req,
        input logic            l2_req,
        input logic            same_line,
        input pmem_arb_state_t last
    );
        if (!vc_req)
            return 1'b0;
        if (!l2_req)
            return 1'b1;
        if (same_line)
            return 1'b1;
        return (last == FILL);
    endfunction

    // Arbitration decision, only meaningful while the port is idle.
    always_comb begin
        start_access = (state == IDLE) && (vc_write || l2_read);
        pick_wb      = grant_writeback(vc_write, l2_read,
                                       vc_address == l2_address, last_grant);
    end

    // Control FSM: grant, strobe until memory responds, pulse the ack,
    // then one dead cycle so a level request can drop before re-arbitration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= FILL;
            pmem_read     <= 1'b0;
            pmem_write    <= 1'b0;
            L2toPmem_busy <= 1'b0;
            mem_ack       <= 1'b0;
            l2_resp       <= 1'b0;
        end else begin
            mem_ack <= 1'b0;
            l2_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_access) begin
                        if (pick_wb) begin
                            state      <= WB;
                            pmem_write <= 1'b1;
                        end else begin
                            state         <= FILL;
                            pmem_read     <= 1'b1;
                            L2toPmem_busy <= 1'b1;
                        end
                    end
                end
                WB: begin
                    if (pmem_resp) begin
                        pmem_write <= 1'b0;
                        mem_ack    <= 1'b1;
                        last_grant <= WB;
                        state      <= RESP;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        pmem_read     <= 1'b0;
                        L2toPmem_busy <= 1'b0;
                        l2_resp       <= 1'b1;
                        last_grant    <= FILL;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Datapath: latch address/data on the grant edge, capture fill data on completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pmem_address <= '0;
            pmem_wdata   <= '0;
            l2_rdata     <= '0;
        end else begin
            if (start_access) begin
                if (pick_wb) begin
                    pmem_address <= {vc_address, {OFFSET_W{1'b0}}};
                    pmem_wdata   <= vc_wdata;
                end else begin
                    pmem_address <= {l2_address, {OFFSET_W{1'b0}}};
                end
            end
            if (state == FILL && pmem_resp)
                l2_rdata <= pmem_rdata;
        end
    end

endmodule

// File: tb/tb_pmem_wb_arbiter.sv
// Directed bench for pmem_wb_arbiter with a small behavioural memory that
// answers each strobe after a programmable number of cycles.
module tb_pmem_wb_arbiter;

    localparam int LINE_ADDR_W = 12;
    localparam int LINE_W      = 128;
    localparam int OFFSET_W    = 4;
    localparam int PA_W        = LINE_ADDR_W + OFFSET_W;

    localparam logic [LINE_W-1:0] WB_DATA   = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    localparam logic [LINE_W-1:0] FILL_DATA = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    localparam logic [LINE_W-1:0] HAZ_DATA  = 128'hA5A5_A5A5_5A5A_5A5A_A5A5_A5A5_5A5A_5A5A;
    localparam logic [LINE_W-1:0] RR_DATA   = 128'hC3C3_0000_C3C3_0000_C3C3_0000_C3C3_0000;
    localparam logic [LINE_W-1:0] CHURN_D1  = 128'hD1D1_D1D1_D1D1_D1D1_D1D1_D1D1_D1D1_D1D1;
    localparam logic [LINE_W-1:0] CHURN_D2  = 128'hD2D2_D2D2_D2D2_D2D2_D2D2_D2D2_D2D2_D2D2;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   vc_write = 1'b0;
    logic [LINE_ADDR_W-1:0] vc_address = '0;
    logic [LINE_W-1:0]      vc_wdata = '0;
    logic                   mem_ack;
    logic                   l2_read = 1'b0;
    logic [LINE_ADDR_W-1:0] l2_address = '0;
    logic [LINE_W-1:0]      l2_rdata;
    logic                   l2_resp;
    logic                   L2toPmem_busy;
    logic                   pmem_read;
    logic                   pmem_write;
    logic [PA_W-1:0]        pmem_address;
    logic [LINE_W-1:0]      pmem_wdata;
    logic [LINE_W-1:0]      pmem_rdata = '0;
    logic                   pmem_resp;

    int   assert_count = 0;
    int   fail_count = 0;

    int   resp_delay = 1;
    int   wait_cnt = 0;
    logic model_resp = 1'b0;
    logic force_resp = 1'b0;
    logic [LINE_W-1:0] mem [logic [PA_W-1:0]];

    assign pmem_resp = model_resp | force_resp;

    pmem_wb_arbiter #(
        .LINE_ADDR_W(LINE_ADDR_W),
        .LINE_W(LINE_W),
        .OFFSET_W(OFFSET_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vc_write(vc_write),
        .vc_address(vc_address),
        .vc_wdata(vc_wdata),
        .mem_ack(mem_ack),
        .l2_read(l2_read),
        .l2_address(l2_address),
        .l2_rdata(l2_rdata),
        .l2_resp(l2_resp),
        .L2toPmem_busy(L2toPmem_busy),
        .pmem_read(pmem_read),
        .pmem_write(pmem_write),
        .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    // Contents of never-written lines: one known line, the rest an address pattern.
    function automatic logic [LINE_W-1:0] fill_pattern(input logic [PA_W-1:0] a);
        if (a == 16'h0100)
            return FILL_DATA;
        return {8{a}};
    endfunction

    // Memory model: answers a held strobe on its resp_delay-th cycle with a
    // one-cycle pmem_resp, storing writes and returning stored or pattern data.
    always @(negedge clk) begin
        if ((pmem_read || pmem_write) && !model_resp) begin
            if (wait_cnt >= resp_delay - 1) begin
                model_resp = 1'b1;
                wait_cnt   = 0;
                if (pmem_write)
                    mem[pmem_address] = pmem_wdata;
                else if (mem.exists(pmem_address))
                    pmem_rdata = mem[pmem_address];
                else
                    pmem_rdata = fill_pattern(pmem_address);
            end else begin
                wait_cnt++;
            end
        end else begin
            model_resp = 1'b0;
            wait_cnt   = 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] got,
                               input logic [LINE_W-1:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic vw, input logic [LINE_ADDR_W-1:0] va,
                                 input logic [LINE_W-1:0] vd, input logic lr,
                                 input logic [LINE_ADDR_W-1:0] la);
        vc_write   = vw;
        vc_address = va;
        vc_wdata   = vd;
        l2_read    = lr;
        l2_address = la;
    endtask

    // Called on a falling edge; returns on the falling edge where the ack is seen.
    task automatic wait_done(input logic want_wb, output int strobes, output logic done);
        strobes = 0;
        done    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (want_wb ? mem_ack : l2_resp) begin
                done = 1'b1;
                break;
            end
            if (pmem_read || pmem_write)
                strobes++;
            @(negedge clk);
        end
    endtask

    initial begin
        int       strobes;
        logic     done;
        int       n;
        logic [3:0] order;
        int       bad;

        // Reset state
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_strobes", {pmem_read, pmem_write}, 2'b00);
        checkOutput("rst_acks", {mem_ack, l2_resp, L2toPmem_busy}, 3'b000);
        checkOutput("rst_addr", pmem_address, '0);
        checkOutput("rst_rdata", l2_rdata, '0);
        reset = 1'b0;
        @(negedge clk);

        // Lone writeback, memory answers on the 4th strobe cycle
        resp_delay = 4;
        applyStimulus(1'b1, 12'h0A3, WB_DATA, 1'b0, '0);
        @(negedge clk);
        checkOutput("wb_strobe", {pmem_write, pmem_read, L2toPmem_busy}, 3'b100);
        checkOutput("wb_addr", pmem_address, 16'h0A30);
        checkOutput("wb_wdata", pmem_wdata, WB_DATA);
        wait_done(1'b1, strobes, done);
        checkOutput("wb_done", done, 1'b1);
        checkOutput("wb_strobe_cycles", strobes, 4);
        checkOutput("wb_ack_cycle", {pmem_write, l2_resp}, 2'b00);
        applyStimulus(1'b0, 12'h0A3, WB_DATA, 1'b0, '0);
        @(negedge clk);
        checkOutput("wb_ack_pulse", {mem_ack, pmem_write, pmem_read}, 3'b000);
        @(negedge clk);

        // Same-line hazard: last grant was WB, yet WB must still go first
        resp_delay = 1;
        applyStimulus(1'b1, 12'h055, HAZ_DATA, 1'b1, 12'h055);
        @(negedge clk);
        checkOutput("haz_first_wb", {pmem_write, pmem_read}, 2'b10);
        checkOutput("haz_addr", pmem_address, 16'h0550);
        wait_done(1'b1, strobes, done);
        checkOutput("haz_wb_done", done, 1'b1);
        applyStimulus(1'b0, 12'h055, HAZ_DATA, 1'b1, 12'h055);
        wait_done(1'b0, strobes, done);
        checkOutput("haz_fill_done", done, 1'b1);
        checkOutput("haz_fill_data", l2_rdata, HAZ_DATA);
        checkOutput("haz_excl", {mem_ack, pmem_read & pmem_write}, 2'b00);
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        @(negedge clk);
        @(negedge clk);

        // Lone fill, two strobe cycles
        resp_delay = 2;
        applyStimulus(1'b0, '0, '0, 1'b1, 12'h010);
        @(negedge clk);
        checkOutput("fill_strobe", {pmem_read, pmem_write, L2toPmem_busy}, 3'b101);
        checkOutput("fill_addr", pmem_address, 16'h0100);
        @(negedge clk);
        checkOutput("fill_busy_held", {pmem_read, L2toPmem_busy, l2_resp}, 3'b110);
        wait_done(1'b0, strobes, done);
        checkOutput("fill_done", done, 1'b1);
        checkOutput("fill_resp_cycle", {L2toPmem_busy, pmem_read, mem_ack}, 3'b000);
        checkOutput("fill_data", l2_rdata, FILL_DATA);
        applyStimulus(1'b0, '0, '0, 1'b0, 12'h010);
        @(negedge clk);
        checkOutput("fill_resp_pulse", l2_resp, 1'b0);
        checkOutput("fill_data_hold", l2_rdata, FILL_DATA);
        @(negedge clk);

        // Round-robin from reset with both requests held continuously
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        resp_delay = 1;
        applyStimulus(1'b1, 12'h001, RR_DATA, 1'b1, 12'h002);
        n     = 0;
        order = '0;
        bad   = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (mem_ack || l2_resp) begin
                order[n] = mem_ack;
                n++;
                if (mem_ack && l2_resp) bad++;
                if (pmem_read || pmem_write) bad++;
                if (pmem_address != (mem_ack ? 16'h0010 : 16'h0020)) bad++;
                @(negedge clk);
                if (pmem_read || pmem_write) bad++;
            end
        end
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        checkOutput("rr_count", n, 4);
        checkOutput("rr_order", order, 4'b0101);
        checkOutput("rr_gaps", bad, 0);
        @(negedge clk);
        @(negedge clk);

        // Reset two cycles into a fill, then re-issue
        resp_delay = 10;
        applyStimulus(1'b0, '0, '0, 1'b1, 12'h030);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstfill_active", {pmem_read, L2toPmem_busy}, 2'b11);
        #2 reset = 1'b1;
        #1;
        checkOutput("rstfill_async", {pmem_read, L2toPmem_busy, l2_resp, mem_ack}, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        resp_delay = 1;
        wait_done(1'b0, strobes, done);
        checkOutput("rstfill_done", done, 1'b1);
        checkOutput("rstfill_data", l2_rdata, {8{16'h0300}});
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        @(negedge clk);
        @(negedge clk);

        // Input churn after grant must not disturb the in-flight writeback
        resp_delay = 3;
        applyStimulus(1'b1, 12'h0B7, CHURN_D1, 1'b0, '0);
        @(negedge clk);
        checkOutput("churn_addr0", pmem_address, 16'h0B70);
        applyStimulus(1'b1, 12'h0FF, CHURN_D2, 1'b0, '0);
        @(negedge clk);
        checkOutput("churn_addr", pmem_address, 16'h0B70);
        checkOutput("churn_wdata", pmem_wdata, CHURN_D1);
        wait_done(1'b1, strobes, done);
        checkOutput("churn_done", done, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        @(negedge clk);
        @(negedge clk);

        // Spurious pmem_resp while idle
        force_resp = 1'b1;
        @(negedge clk);
        force_resp = 1'b0;
        checkOutput("spur_no_ack", {mem_ack, l2_resp, pmem_read, pmem_write}, 4'b0000);
        @(negedge clk);
        checkOutput("spur_still_idle", {mem_ack, l2_resp, pmem_read, pmem_write}, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
